// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl: IF-stage program-counter producer.
// Holds the PC register and computes the next fetch address from sequential
// fetch, stalls, and branch/jump redirects. A redirect that arrives while the
// PC cannot advance is parked in a pending register and applied on the next
// advance. A small RUN/HALT/STEP FSM gives the debug unit run, halt and
// single-step control.
module pc_next_ctrl #(
    parameter int PC_width  = 10,
    parameter int RESET_PC  = 0,
    parameter bit START_RUN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_width-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_width-1:0] jump_target,
    input  logic                halt_instr,
    input  logic                dbg_run,
    input  logic                dbg_step,
    input  logic                dbg_halt,
    output logic [PC_width-1:0] pc_out,
    output logic [PC_width-1:0] pc_next,
    output logic                fetch_en,
    output logic                flush,
    output logic                halted,
    output logic                step_done
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam state_t              RST_STATE = START_RUN ? S_RUN : S_HALT;
    localparam logic [PC_width-1:0] RST_PC    = PC_width'(RESET_PC);

    state_t              state;
    logic                pend_v;
    logic [PC_width-1:0] pend_t;

    logic                adv;
    logic                req_v;     // a new branch/jump request this cycle
    logic [PC_width-1:0] req_t;     // its target (branch beats jump)
    logic                redir;
    logic [PC_width-1:0] redir_t;

    // Advance: running or stepping, no hazard stall, no halt request.
    // A HALT opcode only blocks the advance in RUN; in STEP the stepped
    // instruction is allowed to complete its fetch.
    always_comb begin
        adv = 1'b0;
        if ((state == S_RUN) || (state == S_STEP)) begin
            adv = !stall && !dbg_halt && !((state == S_RUN) && halt_instr);
        end
    end

    // Redirect selection: branch (older, from EX) over jump (ID) over a
    // previously parked redirect.
    always_comb begin
        req_v   = branch_taken || jump;
        req_t   = branch_taken ? branch_target : jump_target;
        redir   = req_v || pend_v;
        redir_t = req_v ? req_t : pend_t;
    end

    // Next-PC mux: hold when not advancing, otherwise redirect or increment
    // (the increment wraps silently at the top of the address space).
    always_comb begin
        pc_next = pc_out;
        if (adv) begin
            pc_next = redir ? redir_t : (pc_out + PC_width'(1));
        end
    end

    assign fetch_en = adv;
    assign flush    = adv && redir;
    assign halted   = (state == S_HALT);

    // PC register: always loads pc_next, which already encodes the hold case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_out <= RST_PC;
        end else begin
            pc_out <= pc_next;
        end
    end

    // Pending redirect: park a request that cannot be taken now (newest
    // request wins), drop it once a redirect is actually applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v <= 1'b0;
            pend_t <= '0;
        end else if (!adv && req_v) begin
            pend_v <= 1'b1;
            pend_t <= req_t;
        end else if (adv && redir) begin
            pend_v <= 1'b0;
        end
    end

    // Debug FSM with registered step_done pulse one cycle after a step advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            step_done <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state)
                S_RUN: begin
                    if (dbg_halt || halt_instr) begin
                        state <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (dbg_halt) begin
                        state <= S_HALT;
                    end else if (dbg_step) begin
                        state <= S_STEP;
                    end else if (dbg_run) begin
                        state <= S_RUN;
                    end
                end
                S_STEP: begin
                    if (dbg_halt) begin
                        state <= S_HALT;
                    end else if (adv) begin
                        state     <= S_HALT;
                        step_done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule
